// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, active-draw,
// new-frame and frame-count outputs, all describing the same pixel position.
//
// state  | meaning
// IDLE   | held in reset, outputs parked at zero
// RUN    | counters advance one pixel per clock
module video_sig_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int ACTIVE_V = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int FPS      = 60
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(TOTAL_H - 1);
    localparam logic [9:0]  V_LAST   = 10'(TOTAL_V - 1);
    localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
    localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
    localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FP);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FP);
    localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FP + V_SYNC);
    localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        ad_nxt;
    logic        nf_nxt;
    logic [5:0]  fc_nxt;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decode is done on the next position so every flag lands in the same
    // register stage as the counters it describes.
    always_comb begin
        h_nxt  = '0;
        v_nxt  = '0;
        fc_nxt = fc_out;
        if (state == S_RUN) begin
            if (hcount_out == H_LAST) begin
                h_nxt = '0;
                if (vcount_out == V_LAST) begin
                    v_nxt = '0;
                end else begin
                    v_nxt = vcount_out + 10'd1;
                end
            end else begin
                h_nxt = hcount_out + 11'd1;
                v_nxt = vcount_out;
            end
        end
        ad_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_nxt = (v_nxt >= VS_START) && (v_nxt < VS_END);
        nf_nxt = (state == S_RUN) && (h_nxt == H_ACT) && (v_nxt == V_ACT);
        if (nf_nxt) begin
            if (fc_out == FC_LAST) begin
                fc_nxt = '0;
            end else begin
                fc_nxt = fc_out + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else begin
            hcount_out <= h_nxt;
            vcount_out <= v_nxt;
            hs_out     <= hs_nxt;
            vs_out     <= vs_nxt;
            ad_out     <= ad_nxt;
            nf_out     <= nf_nxt;
            fc_out     <= fc_nxt;
        end
    end

endmodule

// File: doc/video_sig_gen.md
VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

Interface
REQ-001: Parameter ACTIVE_H, default 1280, active pixels per line.
REQ-002: Parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003: Parameter H_SYNC, default 40, horizontal sync width in pixels.
REQ-004: Parameter H_BP, default 220, horizontal back porch in pixels.
REQ-005: Parameter ACTIVE_V, default 720, active lines per frame.
REQ-006: Parameter V_FP, default 5, vertical front porch in lines.
REQ-007: Parameter V_SYNC, default 5, vertical sync width in lines.
REQ-008: Parameter V_BP, default 20, vertical back porch in lines.
REQ-009: Parameter FPS, default 60, frame counter modulus.
REQ-010: Port clk_in, input, 1, pixel clock; the block uses one clock, all logic on its rising edge.
REQ-011: Port rst_n_in, input, 1, reset; synchronous and active-low.
REQ-012: Port hcount_out, output, 11, horizontal pixel position.
REQ-013: Port vcount_out, output, 10, vertical line position.
REQ-014: Port hs_out, output, 1, horizontal sync, active-high; feeds the TMDS encoder's control_in[0].
REQ-015: Port vs_out, output, 1, vertical sync, active-high; feeds the TMDS encoder's control_in[1].
REQ-016: Port ad_out, output, 1, active-draw; feeds the TMDS encoder's ve_in.
REQ-017: Port nf_out, output, 1, single-cycle new-frame pulse.
REQ-018: Port fc_out, output, 6, frame count, 0..FPS-1.

Function
REQ-019: TOTAL_H SHALL be ACTIVE_H+H_FP+H_SYNC+H_BP (1650 by default); TOTAL_V SHALL be ACTIVE_V+V_FP+V_SYNC+V_BP (750 by default).
REQ-020: All outputs SHALL be registered, and all SHALL describe the same pixel position (hcount_out, vcount_out) in the same cycle.
REQ-021: State: the block has an internal running flag; IDLE (held in reset) and RUN.
REQ-022: On the first rising edge with rst_n_in high after reset, the block SHALL enter RUN and the outputs SHALL present position (0,0) with ad_out=1.
REQ-023: In RUN, hcount_out SHALL increment by 1 per clock and wrap from TOTAL_H-1 to 0.
REQ-024: vcount_out SHALL increment only in the cycle hcount_out wraps, and SHALL wrap from TOTAL_V-1 to 0 in that same cycle.
REQ-025: ad_out SHALL be 1 iff hcount_out<ACTIVE_H and vcount_out<ACTIVE_V.
REQ-026: hs_out SHALL be 1 iff ACTIVE_H+H_FP <= hcount_out < ACTIVE_H+H_FP+H_SYNC (1390..1429 by default), on every line including vertical blank.
REQ-027: vs_out SHALL be 1 iff ACTIVE_V+V_FP <= vcount_out < ACTIVE_V+V_FP+V_SYNC (725..729 by default), for the full line width.
REQ-028: nf_out SHALL be 1 for exactly one cycle per frame, when hcount_out==ACTIVE_H and vcount_out==ACTIVE_V.
REQ-029: fc_out SHALL increment in the same cycle nf_out rises, and SHALL wrap from FPS-1 to 0.
REQ-030: Counter arithmetic SHALL use the compare-then-reset form; counters SHALL never present values >= TOTAL_H or TOTAL_V.

Reset
REQ-031: While rst_n_in is low at a clock edge, all outputs SHALL be 0 and the block SHALL be in IDLE, including ad_out, nf_out and fc_out.
REQ-032: Reset asserted mid-frame SHALL take effect at the next edge; on release, timing SHALL restart per REQ-022 with fc_out=0.

Verification
REQ-033: Release reset -> first cycle shows hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0; the next cycle shows hcount=1.
REQ-034: Run 1650 cycles from (0,0) -> hcount returns to 0 and vcount=1; hs high only for hcount 1390..1429 (40 cycles); ad low for hcount>=1280.
REQ-035: Run one full frame (1,237,500 cycles) -> exactly one nf pulse at (1280,720); vs high for lines 725..729 (8250 cycles); the position after (1649,749) is (0,0).
REQ-036: Run 60 frames -> fc steps 0..59 and wraps to 0 on the 60th nf pulse; check wrap with FPS=60.
REQ-037: Assert reset at (700,400) for 3 cycles -> outputs are all 0 during reset; after release the first cycle shows (0,0), ad=1, fc=0.
REQ-038: Small parameter set (ACTIVE_H=4, H_FP=1, H_SYNC=2, H_BP=1, ACTIVE_V=3, V_FP=1, V_SYNC=1, V_BP=1, FPS=2) -> exhaustive cycle-by-cycle comparison against a reference model across 3 frames.
